pipelined_addsub: RTL

- Parametrised successor to the team's single-cycle combinational 32-bit adder.
- Adds or subtracts two WIDTH-bit operands through a carry-segmented pipeline, one SEG_W-bit slice per stage.
- Full valid/ready handshake on input and output, with backpressure.
- Used wherever a wide add must close timing at high clock rates, e.g. accumulator front ends and address generators.

---
 rtl/pipelined_addsub_pkg.sv | 17 +
 rtl/pipelined_addsub_seg_stage.sv | 129 ++++++++++++
 rtl/pipelined_addsub.sv | 95 +++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Optional saturation is enabled by the PIPELINED_ADDSUB_SAT_EN macro (see pipelined_addsub.sv).
package pipelined_addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // One bit of the signed saturation pattern, independent of word width.
    // msb is the sign of operand A: a positive overflow (msb=0) clamps to
    // 0111...1 and a negative overflow (msb=1) clamps to 1000...0.
    function automatic logic sat_clamp(input logic msb, input logic is_top);
        return is_top ? msb : ~msb;
    endfunction

endpackage

// File: rtl/pipelined_addsub_seg_stage.sv
// One carry segment of the pipelined adder: adds slice IDX of the operands
// plus the incoming carry, merges it into the partial result and registers
// everything the later segments still need. The last segment also forms
// carry/borrow-out, signed overflow and the optional saturated result.
module addsub_seg_stage
    import pipelined_addsub_pkg::*;
#(
    parameter int SEG_W = 8,
    parameter int WIDTH = 32,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_in,
    output logic             valid_out,
    input  logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    input  logic             carry_in,
    input  op_t              op_in,
    input  logic             sat_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out,
    output logic             carry_out,
    output op_t              op_out,
    output logic             sat_out,
    output logic             co_out,
    output logic             ovf_out
);

    localparam int   LO   = IDX * SEG_W;
    localparam logic LAST = ((LO + SEG_W) == WIDTH);

    logic             valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    op_t              op_reg;
    logic             sat_reg;
    logic             co_reg;
    logic             ovf_reg;

    logic [SEG_W:0]   slice_sum;
    logic [WIDTH-1:0] slice_ext;
    logic [WIDTH-1:0] res_merged;
    logic [WIDTH-1:0] clamp_vec;
    logic [WIDTH-1:0] res_next;
    logic             co_next;
    logic             ovf_next;

    // Slice adder; the extra top bit is this segment's carry-out.
    assign slice_sum = {1'b0, a_in[LO +: SEG_W]} + {1'b0, b_in[LO +: SEG_W]}
                     + {{SEG_W{1'b0}}, carry_in};

    // Place the new slice at its bit position; upper slices of res_in are still zero.
    always_comb begin
        slice_ext = '0;
        slice_ext[LO +: SEG_W] = slice_sum[SEG_W-1:0];
    end

    assign res_merged = res_in | slice_ext;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_clamp
            assign clamp_vec[gi] = sat_clamp(a_in[WIDTH-1], (gi == WIDTH - 1));
        end
    endgenerate

    // Final-segment flags and saturation; earlier segments just pass the partial sum.
    always_comb begin
        res_next = res_merged;
        co_next  = 1'b0;
        ovf_next = 1'b0;
        if (LAST) begin
            co_next  = (op_in == OP_SUB) ? ~slice_sum[SEG_W] : slice_sum[SEG_W];
            ovf_next = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                       (res_merged[WIDTH-1] != a_in[WIDTH-1]);
            if (sat_in && ovf_next) begin
                res_next = clamp_vec;
            end
        end
    end

    // A stage can take a new beat when empty or when its current beat moves on.
    assign ready_in = !valid_reg || ready_out;

    // Pipeline register: data only changes on a real transfer so stalls hold it stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            op_reg    <= OP_ADD;
            sat_reg   <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (ready_in) begin
            valid_reg <= valid_in;
            if (valid_in) begin
                a_reg     <= a_in;
                b_reg     <= b_in;
                res_reg   <= res_next;
                carry_reg <= slice_sum[SEG_W];
                op_reg    <= op_in;
                sat_reg   <= sat_in;
                co_reg    <= co_next;
                ovf_reg   <= ovf_next;
            end
        end
    end

    assign valid_out = valid_reg;
    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign res_out   = res_reg;
    assign carry_out = carry_reg;
    assign op_out    = op_reg;
    assign sat_out   = sat_reg;
    assign co_out    = co_reg;
    assign ovf_out   = ovf_reg;

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined adder/subtractor with valid/ready on both sides.
// WIDTH must be a multiple of SEGS; each of the SEGS stages resolves one slice.
// Define PIPELINED_ADDSUB_SAT_EN to add the 'sat' input that clamps
// overflowing results to the signed max/min instead of wrapping.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  op_t              op,
`ifdef PIPELINED_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int SEG_W = WIDTH / SEGS;

    logic             valid_pipe [0:SEGS];
    logic             ready_pipe [0:SEGS];
    logic [WIDTH-1:0] a_pipe     [0:SEGS];
    logic [WIDTH-1:0] b_pipe     [0:SEGS];
    logic [WIDTH-1:0] res_pipe   [0:SEGS];
    logic             carry_pipe [0:SEGS];
    op_t              op_pipe    [0:SEGS];
    logic             sat_pipe   [0:SEGS];
    logic             co_pipe    [0:SEGS-1];
    logic             ovf_pipe   [0:SEGS-1];

    // Subtraction is a + ~b + ~ci, so borrow-in becomes an inverted carry-in.
    assign valid_pipe[0] = in_valid;
    assign a_pipe[0]     = a;
    assign b_pipe[0]     = (op == OP_SUB) ? ~b : b;
    assign carry_pipe[0] = (op == OP_SUB) ? ~ci : ci;
    assign res_pipe[0]   = '0;
    assign op_pipe[0]    = op;
`ifdef PIPELINED_ADDSUB_SAT_EN
    assign sat_pipe[0]   = sat;
`else
    assign sat_pipe[0]   = 1'b0;
`endif
    assign ready_pipe[SEGS] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < SEGS; gi++) begin : g_stage
            addsub_seg_stage #(
                .SEG_W (SEG_W),
                .WIDTH (WIDTH),
                .IDX   (gi)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .valid_in  (valid_pipe[gi]),
                .ready_in  (ready_pipe[gi]),
                .valid_out (valid_pipe[gi+1]),
                .ready_out (ready_pipe[gi+1]),
                .a_in      (a_pipe[gi]),
                .b_in      (b_pipe[gi]),
                .res_in    (res_pipe[gi]),
                .carry_in  (carry_pipe[gi]),
                .op_in     (op_pipe[gi]),
                .sat_in    (sat_pipe[gi]),
                .a_out     (a_pipe[gi+1]),
                .b_out     (b_pipe[gi+1]),
                .res_out   (res_pipe[gi+1]),
                .carry_out (carry_pipe[gi+1]),
                .op_out    (op_pipe[gi+1]),
                .sat_out   (sat_pipe[gi+1]),
                .co_out    (co_pipe[gi]),
                .ovf_out   (ovf_pipe[gi])
            );
        end
    endgenerate

    // The last stage's registers are the outputs directly.
    assign in_ready  = ready_pipe[0];
    assign out_valid = valid_pipe[SEGS];
    assign sum       = res_pipe[SEGS];
    assign co        = co_pipe[SEGS-1];
    assign ovf       = ovf_pipe[SEGS-1];

endmodule
